ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit for the EX stage. It consumes the two 32-bit operand values resolved by the ID-stage register bypass muxes and carried through the ID/EX pipeline register. It produces the HI/LO result pair for MULT/MULTU/DIV/DIVU. It raises a stall request to the pipeline controller while a divide is in flight.

---
 rtl/ex_muldiv.sv | 140 ++++++++++++++
 tb/tb_ex_muldiv.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit for the EX stage.
//
// Multiplies complete in a single edge (result registered straight into
// hi_out/lo_out). Divides run a 32-step restoring division, one step per
// cycle, followed by a sign fix-up cycle.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         mul/div instruction in EX (sampled only in IDLE)
//   op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a     rs value (dividend / multiplicand)
//   operand_b     rt value (divisor / multiplier)
//   flush         synchronous abort, no result produced
//   stall_req     combinational hold request to the pipeline controller
//   result_valid  one-cycle pulse, hi_out/lo_out updated
//   hi_out        upper product word or remainder
//   lo_out        lower product word or quotient
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for start; multiplies complete from here
// DIV_RUN | one restoring-division step per cycle, 32 cycles
// FIXUP   | apply latched signs, register quotient/remainder

module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        stall_req,
  output logic        result_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, DIV_RUN, FIXUP} state_t;

  state_t      state, state_nxt;
  logic [31:0] div_mag;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [4:0]  cnt;
  logic        q_neg;
  logic        r_neg;

  logic        mul_go;
  logic        div_go;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [32:0] rem_shift;
  logic [31:0] rem_diff;
  logic        step_ok;

  assign mul_go = (state == IDLE) && start && !op[1] && !flush;
  assign div_go = (state == IDLE) && start &&  op[1] && !flush;

  // op[0] selects unsigned; signed divide works on magnitudes
  assign a_abs = (!op[0] && operand_a[31]) ? -operand_a : operand_a;
  assign b_abs = (!op[0] && operand_b[31]) ? -operand_b : operand_b;

  // Extending to 64 bits first makes the low 64 bits of one unsigned
  // multiply correct for both the signed and unsigned forms.
  assign mul_a   = op[0] ? {32'b0, operand_a} : {{32{operand_a[31]}}, operand_a};
  assign mul_b   = op[0] ? {32'b0, operand_b} : {{32{operand_b[31]}}, operand_b};
  assign product = mul_a * mul_b;

  // The partial remainder always stays below the divisor, so when the
  // 33-bit compare succeeds the difference fits in 32 bits.
  assign rem_shift = {rem, quo[31]};
  assign step_ok   = rem_shift >= {1'b0, div_mag};
  assign rem_diff  = rem_shift[31:0] - div_mag;

  assign stall_req = ((state == IDLE) && start && op[1]) || (state == DIV_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && op[1]) state_nxt = DIV_RUN;
        DIV_RUN: if (cnt == 5'd31) state_nxt = FIXUP;
        FIXUP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_mag      <= '0;
      rem          <= '0;
      quo          <= '0;
      cnt          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (mul_go) begin
        hi_out       <= product[63:32];
        lo_out       <= product[31:0];
        result_valid <= 1'b1;
      end
      if (div_go) begin
        div_mag <= b_abs;
        quo     <= a_abs;
        rem     <= '0;
        cnt     <= '0;
        q_neg   <= !op[0] && (operand_a[31] ^ operand_b[31]);
        r_neg   <= !op[0] && operand_a[31];
      end
      if (state == DIV_RUN && !flush) begin
        cnt <= cnt + 5'd1;
        rem <= step_ok ? rem_diff : rem_shift[31:0];
        quo <= {quo[30:0], step_ok};
      end
      if (state == FIXUP && !flush) begin
        lo_out       <= q_neg ? -quo : quo;
        hi_out       <= r_neg ? -rem : rem;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        scoreboard[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  ex_muldiv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic operators on 64-bit values, divide-by-zero
  // handled as quotient magnitude all-ones and remainder magnitude |a|.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [63:0] p;
    longint      sa, sbv, q, m;
    logic [31:0] am;
    case (o)
      2'b00: begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = sa * sbv;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        p    = {32'b0, a} * {32'b0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          am   = a[31] ? -a : a;
          r.lo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
          r.hi = a[31] ? -am : am;
        end else begin
          sa  = longint'($signed(a));
          sbv = longint'($signed(b));
          q   = sa / sbv;
          m   = sa % sbv;
          r.lo = q[31:0];
          r.hi = m[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Called just after a negedge. Returns in the cycle result_valid is high
  // (or after the cycle budget runs out). inject_at > 0 re-asserts start
  // with a MULTU in that cycle after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input string tag);
    res_t e;
    int   cycles;
    int   stalls;
    scoreboard.push_back(model(o, a, b));
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    #1;
    check({tag, " stall_at_start"}, {63'b0, stall_req}, {63'b0, o[1]});
    stalls = stall_req ? 1 : 0;
    @(negedge clk);
    cycles = 1;
    while (!result_valid && cycles < 40) begin
      if (cycles == inject_at) begin
        start     = 1'b1;
        op        = 2'b01;
        operand_a = 32'd3;
        operand_b = 32'd4;
      end else begin
        start = 1'b0;
      end
      #1;
      if (stall_req) stalls++;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, " valid"}, {63'b0, result_valid}, 64'd1);
    check({tag, " latency"}, 64'(cycles), o[1] ? 64'd34 : 64'd1);
    check({tag, " stall_cycles"}, 64'(stalls), o[1] ? 64'd33 : 64'd0);
    e = scoreboard.pop_front();
    check({tag, " hi"}, {32'b0, hi_out}, {32'b0, e.hi});
    check({tag, " lo"}, {32'b0, lo_out}, {32'b0, e.lo});
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  initial begin
    int pulses;
    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    op        = 2'b00;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset valid", {63'b0, result_valid}, 64'd0);
    check("reset stall", {63'b0, stall_req}, 64'd0);
    check("reset hi", {32'b0, hi_out}, 64'd0);
    check("reset lo", {32'b0, lo_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    check("multu_max hi const", {32'b0, hi_out}, 64'h0000_0000_FFFF_FFFE);
    check("multu_max lo const", {32'b0, lo_out}, 64'h1);
    @(negedge clk);
    check("mul pulse width", {63'b0, result_valid}, 64'd0);
    check("mul hold hi", {32'b0, hi_out}, 64'h0000_0000_FFFF_FFFE);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");
    check("mult_neg lo const", {32'b0, lo_out}, 64'h0000_0000_FFFF_FFF1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, "mult_min");
    check("mult_min hi const", {32'b0, hi_out}, 64'h0000_0000_4000_0000);
    @(negedge clk);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    check("div_m7_2 lo const", {32'b0, lo_out}, 64'h0000_0000_FFFF_FFFD);
    check("div_m7_2 hi const", {32'b0, hi_out}, 64'h0000_0000_FFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 5, "divu_100_7_inject");
    check("divu_100_7 lo const", {32'b0, lo_out}, 64'd14);
    run_op(2'b11, 32'd7, 32'd0, 0, "divu_by_zero");
    check("divu_by_zero hi const", {32'b0, hi_out}, 64'd7);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    check("div_min_m1 lo const", {32'b0, lo_out}, 64'h0000_0000_8000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, "div_neg_by_zero");
    check("div_neg_by_zero lo const", {32'b0, lo_out}, 64'h1);
    @(negedge clk);

    // flush ten cycles into a divide
    start = 1'b1; op = 2'b10; operand_a = 32'h1234; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush idle stall", {63'b0, stall_req}, 64'd0);
    check("flush valid", {63'b0, result_valid}, 64'd0);
    check("flush hold hi", {32'b0, hi_out}, {32'b0, last_hi});
    check("flush hold lo", {32'b0, lo_out}, {32'b0, last_lo});
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("flush no result", 64'(pulses), 64'd0);
    run_op(2'b11, 32'd9, 32'd3, 0, "divu_after_flush");
    @(negedge clk);

    // flush together with start in IDLE
    start = 1'b1; flush = 1'b1; op = 2'b01; operand_a = 32'd5; operand_b = 32'd5;
    #1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start valid", {63'b0, result_valid}, 64'd0);
    check("flush_start hold lo", {32'b0, lo_out}, {32'b0, last_lo});
    @(negedge clk);
    check("flush_start no div", {63'b0, stall_req}, 64'd0);

    // asynchronous reset in the middle of DIV_RUN
    start = 1'b1; op = 2'b11; operand_a = 32'd1000; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset valid", {63'b0, result_valid}, 64'd0);
    check("midreset stall", {63'b0, stall_req}, 64'd0);
    check("midreset hi", {32'b0, hi_out}, 64'd0);
    check("midreset lo", {32'b0, lo_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset idle", {63'b0, stall_req}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 50)),
             0, "random");
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
